// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding,
// default operand width and the iteration-counter width helper.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Wide enough to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_mul_sign_mag.sv
// Combinational two's-complement to sign/magnitude converter. With mode=0 the
// MSB is not treated as a sign and neg_in alone decides whether to negate.
module seq_mul_sign_mag #(
    parameter int W = 4
) (
    input  logic [W-1:0] value,
    input  logic         mode,
    input  logic         neg_in,
    output logic [W-1:0] mag,
    output logic         neg
);

    always_comb begin
        neg = mode ? value[W-1] : neg_in;
        // The most-negative input negates to itself, which reads correctly as
        // the unsigned magnitude 2^(W-1).
        mag = neg ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with start/busy/done handshake. Signed
// operands are multiplied as magnitudes and the sign is reapplied at the end.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [2*WIDTH-1:0] magnitude,
    output logic               sign
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg_op;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_a;
    logic             neg_b;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    prod_next;
    logic             sign_req;
    logic             sign_next;
    logic             last;

    seq_mul_sign_mag #(.W(WIDTH)) u_mag_a (
        .value  (a),
        .mode   (signed_mode),
        .neg_in (1'b0),
        .mag    (mag_a),
        .neg    (neg_a)
    );

    seq_mul_sign_mag #(.W(WIDTH)) u_mag_b (
        .value  (b),
        .mode   (signed_mode),
        .neg_in (1'b0),
        .mag    (mag_b),
        .neg    (neg_b)
    );

    always_comb begin
        addend   = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        acc_next = acc + addend;
        // A zero product is never reported as negative.
        sign_req = neg_op && (acc_next != '0);
        last     = (cnt == CW'(WIDTH - 1));
    end

    // Same negation path, bypass mode: negate the final magnitude on request.
    seq_mul_sign_mag #(.W(PW)) u_neg_p (
        .value  (acc_next),
        .mode   (1'b0),
        .neg_in (sign_req),
        .mag    (prod_next),
        .neg    (sign_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg_op    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            magnitude <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg_op <= neg_a ^ neg_b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        magnitude <= acc_next;
                        sign      <= sign_next;
                        product   <= prod_next;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH 2, 4 and 8: directed cases
// followed by random operands against an integer-arithmetic reference.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic st2, sm2, bz2, dn2, sg2;
    logic [1:0] a2, b2;
    logic [3:0] p2, m2;
    logic st4, sm4, bz4, dn4, sg4;
    logic [3:0] a4, b4;
    logic [7:0] p4, m4;
    logic st8, sm8, bz8, dn8, sg8;
    logic [7:0] a8, b8;
    logic [15:0] p8, m8;

    int nchk = 0;
    int nfail = 0;

    seq_multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .signed_mode(sm2), .a(a2), .b(b2),
        .busy(bz2), .done(dn2), .product(p2), .magnitude(m2), .sign(sg2));
    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(bz4), .done(dn4), .product(p4), .magnitude(m4), .sign(sg4));
    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(bz8), .done(dn8), .product(p8), .magnitude(m8), .sign(sg8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers and multiply.
    function automatic void model(input int w, input logic sm, input logic [15:0] aa,
                                  input logic [15:0] bb, output logic [31:0] ep,
                                  output logic [31:0] em, output logic es);
        longint full, va, vb, p;
        full = longint'(1) << w;
        va = longint'(aa) & (full - 1);
        vb = longint'(bb) & (full - 1);
        if (sm && aa[w-1]) va = va - full;
        if (sm && bb[w-1]) vb = vb - full;
        p  = va * vb;
        es = (p < 0);
        em = 32'((p < 0) ? -p : p);
        ep = 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic drive(input int w, input logic st, input logic sm,
                         input logic [15:0] aa, input logic [15:0] bb);
        case (w)
            2: begin st2 = st; sm2 = sm; a2 = aa[1:0]; b2 = bb[1:0]; end
            4: begin st4 = st; sm4 = sm; a4 = aa[3:0]; b4 = bb[3:0]; end
            default: begin st8 = st; sm8 = sm; a8 = aa[7:0]; b8 = bb[7:0]; end
        endcase
    endtask

    task automatic sample(input int w, output logic bz, output logic dn, output logic sg,
                          output logic [31:0] p, output logic [31:0] m);
        case (w)
            2: begin bz = bz2; dn = dn2; sg = sg2; p = {28'd0, p2}; m = {28'd0, m2}; end
            4: begin bz = bz4; dn = dn4; sg = sg4; p = {24'd0, p4}; m = {24'd0, m4}; end
            default: begin bz = bz8; dn = dn8; sg = sg8; p = {16'd0, p8}; m = {16'd0, m8}; end
        endcase
    endtask

    // One operation from a negedge; returns at the negedge where done is seen.
    // Inputs are scrambled after acceptance; poke_at re-asserts start mid-run.
    task automatic op(input int w, input logic sm, input logic [15:0] aa,
                      input logic [15:0] bb, input int poke_at, input string tag);
        logic bz, dn, sg, es;
        logic [31:0] p, m, ep, em;
        int k, bcnt;
        model(w, sm, aa, bb, ep, em, es);
        drive(w, 1'b1, sm, aa, bb);
        @(negedge clk);
        drive(w, 1'b0, ~sm, ~aa, ~bb);
        k = 0;
        bcnt = 0;
        sample(w, bz, dn, sg, p, m);
        while (!dn && k < 4 * w + 4) begin
            if (bz) bcnt++;
            if (k == poke_at) drive(w, 1'b1, sm, 16'd1, 16'd1);
            else drive(w, 1'b0, ~sm, ~aa, ~bb);
            @(negedge clk);
            k++;
            sample(w, bz, dn, sg, p, m);
        end
        drive(w, 1'b0, sm, aa, bb);
        check({tag, "_latency"}, 32'(k), 32'(w));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(w));
        check({tag, "_done"}, {31'd0, dn}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, bz}, 32'd0);
        check({tag, "_product"}, p, ep);
        check({tag, "_magnitude"}, m, em);
        check({tag, "_sign"}, {31'd0, sg}, {31'd0, es});
    endtask

    initial begin
        logic bz, dn, sg;
        logic [31:0] p, m;
        int k, dcount;

        rst = 1'b1;
        drive(2, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        sample(4, bz, dn, sg, p, m);
        check("reset_busy", {31'd0, bz}, 32'd0);
        check("reset_done", {31'd0, dn}, 32'd0);
        check("reset_product", p, 32'd0);
        check("reset_magnitude", m, 32'd0);
        check("reset_sign", {31'd0, sg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op(4, 1'b0, 16'd15, 16'd15, -1, "unsigned_max");
        check("unsigned_max_const", p, 32'h0);
        sample(4, bz, dn, sg, p, m);
        check("unsigned_max_e1", p, 32'hE1);
        @(negedge clk);
        op(4, 1'b1, 16'hD, 16'd5, -1, "signed_mixed");
        sample(4, bz, dn, sg, p, m);
        check("signed_mixed_f1", p, 32'hF1);
        @(negedge clk);
        op(4, 1'b1, 16'h8, 16'h8, -1, "signed_m8m8");
        sample(4, bz, dn, sg, p, m);
        check("signed_m8m8_40", p, 32'h40);
        @(negedge clk);
        op(4, 1'b1, 16'h8, 16'h7, -1, "signed_m8p7");
        sample(4, bz, dn, sg, p, m);
        check("signed_m8p7_c8", p, 32'hC8);
        check("signed_m8p7_56", m, 32'd56);
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        drive(4, 1'b1, 1'b0, 16'd3, 16'd3);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 sample(4, bz, dn, sg, p, m);
        check("midrun_rst_busy", {31'd0, bz}, 32'd0);
        check("midrun_rst_done", {31'd0, dn}, 32'd0);
        check("midrun_rst_product", p, 32'd0);
        check("midrun_rst_magnitude", m, 32'd0);
        check("midrun_rst_sign", {31'd0, sg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample(4, bz, dn, sg, p, m);
            if (dn || bz) dcount++;
        end
        check("after_rst_no_activity", 32'(dcount), 32'd0);

        // Zero product in signed mode, with a start pulse ignored mid-run.
        op(4, 1'b1, 16'hB, 16'd0, 1, "zero_poke");
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample(4, bz, dn, sg, p, m);
            if (dn || bz) dcount++;
        end
        check("zero_poke_single_done", 32'(dcount), 32'd0);
        check("zero_poke_product_held", p, 32'd0);

        // Back-to-back: start held high from the first run through DONE.
        drive(4, 1'b1, 1'b0, 16'd3, 16'd3);
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 16'd2, 16'd2);
        k = 0;
        sample(4, bz, dn, sg, p, m);
        while (!dn && k < 20) begin
            @(negedge clk);
            k++;
            sample(4, bz, dn, sg, p, m);
        end
        check("b2b_first_latency", 32'(k), 32'd4);
        check("b2b_first_product", p, 32'd9);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
        sample(4, bz, dn, sg, p, m);
        check("b2b_no_idle_busy", {31'd0, bz}, 32'd1);
        check("b2b_no_idle_done", {31'd0, dn}, 32'd0);
        k = 0;
        while (!dn && k < 20) begin
            @(negedge clk);
            k++;
            sample(4, bz, dn, sg, p, m);
        end
        check("b2b_second_latency", 32'(k), 32'd4);
        check("b2b_second_product", p, 32'd4);
        check("b2b_second_magnitude", m, 32'd4);
        @(negedge clk);

        // Random sweep; an optional idle gap exercises both the IDLE and DONE start paths.
        for (int i = 0; i < 1000; i++) begin
            op(2, 1'($urandom_range(1)), 16'($urandom), 16'($urandom), -1, "rand_w2");
            if ($urandom_range(1) == 1) @(negedge clk);
        end
        for (int i = 0; i < 200; i++) begin
            op(4, 1'($urandom_range(1)), 16'($urandom), 16'($urandom), -1, "rand_w4");
            if ($urandom_range(1) == 1) @(negedge clk);
        end
        for (int i = 0; i < 1000; i++) begin
            op(8, 1'($urandom_range(1)), 16'($urandom), 16'($urandom), -1, "rand_w8");
            if ($urandom_range(1) == 1) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, multi-cycle shift-add multiplier with a start/busy/done handshake.
- Supports both unsigned and two's-complement signed operands, selected per operation.
- Produces the full-width product plus a sign/magnitude pair that feeds the 7-segment display converter.
- Successor to the fixed 2-bit combinational unsigned multiplier; sits between operand switches/registers and the display path.

Parameters:
- WIDTH, 4, operand width in bits (2..16); product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiplication; sampled on rising edge of clk
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when product, magnitude and sign are updated
- product  output  2*WIDTH  result; two's complement if signed_mode, else unsigned
- magnitude  output  2*WIDTH  absolute value of the result, unsigned, for display
- sign  output  1  1 = result negative; always 0 in unsigned mode or for a zero result

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high. While rst=1: state=IDLE; busy, done, sign=0; product=0; magnitude=0; all internal registers cleared.
- Reset mid-operation aborts immediately. After rst falls, the block idles until a new start.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b, signed_mode.
  - In signed mode, convert each operand to a WIDTH-bit unsigned magnitude; the most-negative value (-2^(WIDTH-1)) maps to 2^(WIDTH-1), which fits.
  - Record neg = a[MSB]^b[MSB] (signed mode only); clear the 2*WIDTH accumulator; load iteration counter=0; go to RUN.
- RUN (busy=1):
  - Each cycle: if multiplier LSB=1, add multiplicand<<counter to the accumulator; shift the multiplier right; increment counter.
  - After exactly WIDTH RUN cycles, go to DONE.
  - The accumulator never overflows 2*WIDTH bits.
- DONE entry (registered on the last RUN edge):
  - magnitude = accumulator.
  - sign = neg & (accumulator != 0).
  - product = sign ? -accumulator : accumulator, in 2*WIDTH two's complement.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no dead cycle). Otherwise go to IDLE.
- Latency: start sampled at edge E0 → busy high after E0 → done, product, magnitude and sign valid after edge E_WIDTH. That is WIDTH cycles; throughput is one result per WIDTH+1 cycles.
- Output holding: product, magnitude and sign keep their last values during IDLE and RUN; they change only on DONE entry or reset.
- Handshake:
  - start while busy=1 is ignored: no queuing, no corruption of the operation in flight.
  - Changes on a, b or signed_mode after acceptance have no effect.
- Width rules:
  - Unsigned range: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - Signed range: max (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits as positive in 2*WIDTH bits.
  - No saturation logic is required.

Decomposition:
- Shared package/include:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH constant;
  - counter width macro = clog2(WIDTH)+1.
- One natural sub-module: seq_mul_sign_mag. It is combinational, parametrised by width, and converts a two's-complement value to (magnitude, negative flag) with a mode bit to bypass.
  - Instantiated twice for the operands.
  - Its negate path is reused for the final product negation.
- The existing BCD/7-segment converter stays external and consumes magnitude and sign.

Test Plan (WIDTH=4 unless stated):
- Unsigned max: signed_mode=0, a=15, b=15, start → done after 4 cycles; product=8'hE1 (225), magnitude=225, sign=0; busy high exactly 4 cycles.
- Signed mixed: signed_mode=1, a=4'b1101 (-3), b=5 → product=8'hF1 (-15), magnitude=15, sign=1.
- Signed extremes: a=-8, b=-8 → product=8'h40 (64), sign=0. Then a=-8, b=7 → product=8'hC8 (-56), magnitude=56, sign=1.
- Zero and busy handling:
  - signed_mode=1, a=-5, b=0 → product=0, sign=0.
  - Assert start with a=1, b=1 during RUN → ignored; result stays 0 and done pulses once.
- Reset and back-to-back:
  - Assert rst asynchronously mid-RUN → busy, done, product, magnitude, sign read 0 immediately; no done pulse after release.
  - Start 3*3 and hold start high with a=2, b=2 during DONE → second operation accepted with no idle cycle; results 9 then 4.
- Parameter sweep: WIDTH=2 and WIDTH=8, 1000 random operands in both modes, checked against a reference model → all products, magnitudes and signs match; latency equals WIDTH.
